digit_entry_ctrl: RTL and testbench
===================================

DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. All state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_valid  input  1  single-cycle key strobe.
REQ-005 key_code  input  4  key code, sampled when key_valid=1: 0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF invalid.
REQ-006 sr_ce  output  1  clock enable to the 8-digit shift register.
REQ-007 sr_din  output  4  data to the shift register, valid when sr_ce=1.
REQ-008 digit_count  output  4  number of digits entered, range 0-8.
REQ-009 full  output  1  high when digit_count==8.
REQ-010 busy  output  1  high while a clear sequence is running.
REQ-011 locked  output  1  high after an accepted ENTER, until the next CLEAR.
REQ-012 entered  output  1  single-cycle pulse when an ENTER is accepted.
REQ-013 key_drop  output  1  single-cycle pulse when a key strobe is rejected.

Function
REQ-014 The FSM SHALL have three states, IDLE, CLEAR and LOCKED, and SHALL enter IDLE on reset.
REQ-015 All outputs SHALL be registered. Each response SHALL appear in the cycle after the key_valid edge, giving a latency of 1.
REQ-016 Digit key in IDLE with digit_count<8: sr_ce=1 and sr_din=key_code for exactly one cycle; digit_count increments by 1.
REQ-017 Digit key in IDLE with digit_count==8: key_drop pulses, sr_ce stays 0, and digit_count stays 8 (no wrap).
REQ-018 CLEAR key in IDLE or LOCKED: the FSM enters CLEAR and drives sr_ce=1 with sr_din=FILL for exactly 8 consecutive cycles; busy=1 for those same 8 cycles.
REQ-019 Clear end: on the edge that ends the 8th fill cycle, the FSM returns to IDLE, digit_count goes to 0, and busy, sr_ce and locked go to 0.
REQ-020 Clear length: the 8 fill cycles SHALL be counted by an internal 3-bit counter and SHALL be independent of digit_count.
REQ-021 ENTER key in IDLE with digit_count>=1: entered pulses for one cycle, the FSM enters LOCKED, and locked=1.
REQ-022 ENTER key in IDLE with digit_count==0: key_drop pulses and the state is unchanged.
REQ-023 In LOCKED, digit and ENTER keys SHALL pulse key_drop. Only CLEAR SHALL be accepted.
REQ-024 In CLEAR, any key_valid SHALL pulse key_drop, and the clear sequence SHALL continue unaffected.
REQ-025 Invalid codes 0xC-0xF SHALL pulse key_drop in every state with no other effect.
REQ-026 sr_ce SHALL never be asserted except per REQ-016 and REQ-018.
REQ-027 key_drop, entered and sr_ce-for-digit SHALL be mutually exclusive in any cycle.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to state IDLE with sr_ce=0, sr_din=0x0, digit_count=0, full=0, busy=0, locked=0, entered=0, key_drop=0, and the fill counter at 0.
REQ-029 Reset during CLEAR SHALL abort the sequence immediately; sr_ce=0 from the next cycle onward.
REQ-030 Reset SHALL take priority over a key_valid strobe in the same cycle, and that key SHALL be discarded.

Configuration
REQ-031 Macro CLEAR_FILL_BLANK_EN: when defined, FILL SHALL be 0xF (blank digit code).
REQ-032 When CLEAR_FILL_BLANK_EN is undefined, FILL SHALL be 0x0.
REQ-033 The macro SHALL NOT affect digit, ENTER or reset behaviour.

Verification
REQ-034 Digit entry: reset, then keys 1,2,3 each 3 cycles apart -> three one-cycle sr_ce pulses with sr_din 1,2,3; digit_count=3; full=0.
REQ-035 Full boundary: 9 digit keys 0-8 -> 8 sr_ce pulses; the 9th key pulses key_drop; digit_count=8; full=1.
REQ-036 Clear: with digit_count=5, key 0xA -> sr_ce=1 for exactly 8 consecutive cycles with sr_din=0x0 (0xF with CLEAR_FILL_BLANK_EN) and busy=1 throughout; then digit_count=0.
REQ-037 Lock: ENTER with count=0 -> key_drop pulse; digit 7 then ENTER -> entered pulse and locked=1; digit 4 -> key_drop pulse; CLEAR -> 8 fill cycles, then locked=0.
REQ-038 Key during clear: key 5 in the 3rd clear cycle -> key_drop pulse and still 8 fill cycles total; rst in the 4th clear cycle -> sr_ce=0 and busy=0 in the next cycle, with digit_count=0.
REQ-039 Invalid code: key 0xE in IDLE -> key_drop pulse only, with digit_count and sr_ce unchanged.

Source files
------------

// File: rtl/digit_entry_ctrl_if.sv
// digit_entry_ctrl_if
// Bundles the keypad strobe and the shift-register / status outputs of
// digit_entry_ctrl.
//   master : key source (drives key_valid/key_code, observes status)
//   slave  : digit_entry_ctrl (consumes keys, drives sr_* and status)
// Signals:
//   key_valid   1  single-cycle key strobe
//   key_code    4  0-9 digit, A CLEAR, B ENTER, C-F invalid
//   sr_ce       1  shift-register clock enable
//   sr_din      4  shift-register data, valid with sr_ce
//   digit_count 4  digits entered, 0-8
//   full        1  digit_count == 8
//   busy        1  clear sequence running
//   locked      1  entry locked by ENTER
//   entered     1  one-cycle pulse on accepted ENTER
//   key_drop    1  one-cycle pulse on rejected key
interface digit_entry_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       sr_ce;
    logic [3:0] sr_din;
    logic [3:0] digit_count;
    logic       full;
    logic       busy;
    logic       locked;
    logic       entered;
    logic       key_drop;

    modport master (
        output key_valid, key_code,
        input  sr_ce, sr_din, digit_count, full, busy, locked, entered, key_drop
    );

    modport slave (
        input  key_valid, key_code,
        output sr_ce, sr_din, digit_count, full, busy, locked, entered, key_drop
    );
endinterface

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl
// Keypad digit-entry controller. Accepts up to 8 digits into an external
// shift register, blanks it with an 8-cycle fill sequence on CLEAR, and
// locks the entry on ENTER. All outputs are registered (latency 1).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  digit_entry_ctrl_if.slave (key strobe in, sr_* and status out)
// Configuration:
//   CLEAR_FILL_BLANK_EN  defined -> fill code 0xF, undefined -> fill code 0x0
//
// State   | meaning
// --------+----------------------------------------------------------
// IDLE    | accepting digits, CLEAR and ENTER
// CLEAR   | shifting the fill code for 8 cycles, all keys dropped
// LOCKED  | entry frozen after ENTER, only CLEAR accepted
module digit_entry_ctrl (
    input logic               clk,
    input logic               rst,
    digit_entry_ctrl_if.slave bus
);

`ifdef CLEAR_FILL_BLANK_EN
    localparam logic [3:0] FILL = 4'hF;
`else
    localparam logic [3:0] FILL = 4'h0;
`endif

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] fill_q, fill_d;
    logic [3:0] digit_count_q, digit_count_d;
    logic       sr_ce_q, sr_ce_d;
    logic [3:0] sr_din_q, sr_din_d;
    logic       full_q, full_d;
    logic       busy_q, busy_d;
    logic       locked_q, locked_d;
    logic       entered_q, entered_d;
    logic       key_drop_q, key_drop_d;

    logic is_digit, is_clear, is_enter;

    assign is_digit = (bus.key_code <= 4'd9);
    assign is_clear = (bus.key_code == KEY_CLEAR);
    assign is_enter = (bus.key_code == KEY_ENTER);

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        digit_count_d = digit_count_q;
        sr_ce_d       = 1'b0;
        sr_din_d      = sr_din_q;
        busy_d        = busy_q;
        locked_d      = locked_q;
        entered_d     = 1'b0;
        key_drop_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        if (digit_count_q < MAX_DIGITS) begin
                            sr_ce_d       = 1'b1;
                            sr_din_d      = bus.key_code;
                            digit_count_d = digit_count_q + 4'd1;
                        end else begin
                            key_drop_d = 1'b1;
                        end
                    end else if (is_clear) begin
                        state_d  = CLEAR;
                        fill_d   = 3'd7;
                        sr_ce_d  = 1'b1;
                        sr_din_d = FILL;
                        busy_d   = 1'b1;
                    end else if (is_enter && (digit_count_q != 4'd0)) begin
                        state_d   = LOCKED;
                        locked_d  = 1'b1;
                        entered_d = 1'b1;
                    end else begin
                        key_drop_d = 1'b1;
                    end
                end
            end

            LOCKED: begin
                if (bus.key_valid) begin
                    if (is_clear) begin
                        state_d  = CLEAR;
                        fill_d   = 3'd7;
                        sr_ce_d  = 1'b1;
                        sr_din_d = FILL;
                        busy_d   = 1'b1;
                    end else begin
                        key_drop_d = 1'b1;
                    end
                end
            end

            CLEAR: begin
                // Fill length comes only from the down-counter; keys are
                // dropped and never disturb the sequence.
                key_drop_d = bus.key_valid;
                if (fill_q == 3'd0) begin
                    state_d       = IDLE;
                    digit_count_d = 4'd0;
                    busy_d        = 1'b0;
                    locked_d      = 1'b0;
                end else begin
                    fill_d   = fill_q - 3'd1;
                    sr_ce_d  = 1'b1;
                    sr_din_d = FILL;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        full_d = (digit_count_d == MAX_DIGITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fill_q        <= 3'd0;
            digit_count_q <= 4'd0;
            sr_ce_q       <= 1'b0;
            sr_din_q      <= 4'h0;
            full_q        <= 1'b0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            entered_q     <= 1'b0;
            key_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            digit_count_q <= digit_count_d;
            sr_ce_q       <= sr_ce_d;
            sr_din_q      <= sr_din_d;
            full_q        <= full_d;
            busy_q        <= busy_d;
            locked_q      <= locked_d;
            entered_q     <= entered_d;
            key_drop_q    <= key_drop_d;
        end
    end

    assign bus.sr_ce       = sr_ce_q;
    assign bus.sr_din      = sr_din_q;
    assign bus.digit_count = digit_count_q;
    assign bus.full        = full_q;
    assign bus.busy        = busy_q;
    assign bus.locked      = locked_q;
    assign bus.entered     = entered_q;
    assign bus.key_drop    = key_drop_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl
// Directed bench for digit_entry_ctrl. Inputs change on the falling edge;
// outputs are sampled on the falling edge after the rising edge that
// consumed the key.
module tb_digit_entry_ctrl;

`ifdef CLEAR_FILL_BLANK_EN
    localparam logic [3:0] FILL = 4'hF;
`else
    localparam logic [3:0] FILL = 4'h0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    digit_entry_ctrl_if bus ();

    digit_entry_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one key for one cycle; returns at the falling edge where the
    // registered response is visible.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts consecutive fill cycles starting at the current sample point.
    task automatic count_fill(input string name, input int already, output int total);
        int n;
        n = already;
        while (bus.sr_ce === 1'b1 && n < 20) begin
            vectors++;
            if (bus.sr_din !== FILL || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s fill cycle %0d: sr_din=%h busy=%b, need sr_din=%h busy=1",
                         name, n, bus.sr_din, bus.busy, FILL);
            end
            n++;
            @(negedge clk);
        end
        total = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.sr_ce !== 1'b0 || bus.sr_din !== 4'h0 || bus.digit_count !== 4'd0 ||
            bus.full !== 1'b0 || bus.busy !== 1'b0 || bus.locked !== 1'b0 ||
            bus.entered !== 1'b0 || bus.key_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ce=%b din=%h cnt=%0d full=%b busy=%b lock=%b ent=%b drop=%b, need all 0",
                     bus.sr_ce, bus.sr_din, bus.digit_count, bus.full, bus.busy,
                     bus.locked, bus.entered, bus.key_drop);
        end
        rst = 1'b0;
    endtask

    task automatic test_digits();
        logic [3:0] k;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            k = 4'(i);
            press(k);
            vectors++;
            if (bus.sr_ce !== 1'b1 || bus.sr_din !== k || bus.key_drop !== 1'b0) begin
                errors++;
                $display("FAIL digit_%0d: ce=%b din=%h drop=%b, need ce=1 din=%h drop=0",
                         i, bus.sr_ce, bus.sr_din, bus.key_drop, k);
            end
            @(negedge clk);
            vectors++;
            if (bus.sr_ce !== 1'b0) begin
                errors++;
                $display("FAIL digit_%0d_pulse_width: ce=%b, need 0", i, bus.sr_ce);
            end
        end
        vectors++;
        if (bus.digit_count !== 4'd3 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL digit_count_3: cnt=%0d full=%b, need cnt=3 full=0",
                     bus.digit_count, bus.full);
        end
    endtask

    task automatic test_full();
        logic [3:0] k;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            k = 4'(i);
            press(k);
            vectors++;
            if (i < 8) begin
                if (bus.sr_ce !== 1'b1 || bus.sr_din !== k || bus.key_drop !== 1'b0 ||
                    bus.digit_count !== 4'(i + 1)) begin
                    errors++;
                    $display("FAIL full_digit_%0d: ce=%b din=%h drop=%b cnt=%0d, need ce=1 din=%h drop=0 cnt=%0d",
                             i, bus.sr_ce, bus.sr_din, bus.key_drop, bus.digit_count, k, i + 1);
                end
            end else begin
                if (bus.sr_ce !== 1'b0 || bus.key_drop !== 1'b1 ||
                    bus.digit_count !== 4'd8 || bus.full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ninth_key: ce=%b drop=%b cnt=%0d full=%b, need ce=0 drop=1 cnt=8 full=1",
                             bus.sr_ce, bus.key_drop, bus.digit_count, bus.full);
                end
            end
        end
    endtask

    task automatic test_clear();
        int total;
        do_reset();
        for (int i = 0; i < 5; i++) press(4'(i + 4));
        press(4'hA);
        count_fill("clear", 0, total);
        vectors++;
        if (total != 8) begin
            errors++;
            $display("FAIL clear_length: got %0d fill cycles, need 8", total);
        end
        vectors++;
        if (bus.digit_count !== 4'd0 || bus.busy !== 1'b0 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: cnt=%0d busy=%b full=%b, need cnt=0 busy=0 full=0",
                     bus.digit_count, bus.busy, bus.full);
        end
    endtask

    task automatic test_lock();
        int total;
        do_reset();
        press(4'hB);
        vectors++;
        if (bus.key_drop !== 1'b1 || bus.entered !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL enter_empty: drop=%b ent=%b lock=%b, need drop=1 ent=0 lock=0",
                     bus.key_drop, bus.entered, bus.locked);
        end
        press(4'h7);
        press(4'hB);
        vectors++;
        if (bus.entered !== 1'b1 || bus.locked !== 1'b1 || bus.key_drop !== 1'b0 ||
            bus.sr_ce !== 1'b0) begin
            errors++;
            $display("FAIL enter_accept: ent=%b lock=%b drop=%b ce=%b, need ent=1 lock=1 drop=0 ce=0",
                     bus.entered, bus.locked, bus.key_drop, bus.sr_ce);
        end
        @(negedge clk);
        vectors++;
        if (bus.entered !== 1'b0 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL enter_pulse_width: ent=%b lock=%b, need ent=0 lock=1",
                     bus.entered, bus.locked);
        end
        press(4'h4);
        vectors++;
        if (bus.key_drop !== 1'b1 || bus.sr_ce !== 1'b0 || bus.digit_count !== 4'd1) begin
            errors++;
            $display("FAIL locked_digit: drop=%b ce=%b cnt=%0d, need drop=1 ce=0 cnt=1",
                     bus.key_drop, bus.sr_ce, bus.digit_count);
        end
        press(4'hA);
        count_fill("lock_clear", 0, total);
        vectors++;
        if (total != 8 || bus.locked !== 1'b0 || bus.digit_count !== 4'd0) begin
            errors++;
            $display("FAIL lock_clear_end: fill=%0d lock=%b cnt=%0d, need fill=8 lock=0 cnt=0",
                     total, bus.locked, bus.digit_count);
        end
    endtask

    task automatic test_key_during_clear();
        int total;
        do_reset();
        press(4'h1);
        press(4'h2);
        press(4'hA);                 // now sampling fill cycle 1
        @(negedge clk);              // cycle 2
        @(negedge clk);              // cycle 3
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        @(negedge clk);              // cycle 4
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        vectors++;
        if (bus.key_drop !== 1'b1 || bus.sr_ce !== 1'b1 || bus.sr_din !== FILL) begin
            errors++;
            $display("FAIL clear_key_drop: drop=%b ce=%b din=%h, need drop=1 ce=1 din=%h",
                     bus.key_drop, bus.sr_ce, bus.sr_din, FILL);
        end
        count_fill("clear_with_key", 3, total);
        vectors++;
        if (total != 8) begin
            errors++;
            $display("FAIL clear_with_key_length: got %0d fill cycles, need 8", total);
        end

        press(4'h3);
        press(4'hA);                 // cycle 1
        repeat (3) @(negedge clk);   // cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (bus.sr_ce !== 1'b0 || bus.busy !== 1'b0 || bus.digit_count !== 4'd0) begin
            errors++;
            $display("FAIL clear_abort: ce=%b busy=%b cnt=%0d, need ce=0 busy=0 cnt=0",
                     bus.sr_ce, bus.busy, bus.digit_count);
        end
        @(negedge clk);
        vectors++;
        if (bus.sr_ce !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort_hold: ce=%b busy=%b, need ce=0 busy=0",
                     bus.sr_ce, bus.busy);
        end

        // Reset and key in the same cycle: key is discarded.
        rst = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h3;
        @(negedge clk);
        rst = 1'b0;
        bus.key_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.sr_ce !== 1'b0 || bus.digit_count !== 4'd0 || bus.key_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_key: ce=%b cnt=%0d drop=%b, need ce=0 cnt=0 drop=0",
                     bus.sr_ce, bus.digit_count, bus.key_drop);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        press(4'h2);
        press(4'hE);
        vectors++;
        if (bus.key_drop !== 1'b1 || bus.sr_ce !== 1'b0 || bus.digit_count !== 4'd1 ||
            bus.busy !== 1'b0 || bus.locked !== 1'b0 || bus.entered !== 1'b0) begin
            errors++;
            $display("FAIL invalid_code: drop=%b ce=%b cnt=%0d busy=%b lock=%b ent=%b, need drop=1 ce=0 cnt=1 busy=0 lock=0 ent=0",
                     bus.key_drop, bus.sr_ce, bus.digit_count, bus.busy, bus.locked, bus.entered);
        end
        @(negedge clk);
        vectors++;
        if (bus.key_drop !== 1'b0) begin
            errors++;
            $display("FAIL invalid_pulse_width: drop=%b, need 0", bus.key_drop);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        test_reset();
        test_digits();
        test_full();
        test_clear();
        test_lock();
        test_key_during_clear();
        test_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
